// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side signal bundle between the core datapath and the hazard/stall controller.
interface hazard_stall_controller_if #(
    parameter int unsigned RegAddrWidth = 5,
    parameter int unsigned CntWidth     = 16
);
    // hazard sources from ID/EX/MEM
    logic [RegAddrWidth-1:0] id_rs1;
    logic [RegAddrWidth-1:0] id_rs2;
    logic                    id_rs1_used;
    logic                    id_rs2_used;
    logic [RegAddrWidth-1:0] ex_rd;
    logic                    ex_mem_read;
    logic                    ex_md_valid;
    logic                    ex_branch_taken;
    logic                    mem_req;
    logic                    dmem_ready;
    logic                    md_done;

    // sequencing controls back to the pipeline registers and MUL/DIV unit
    logic                    pc_stall;
    logic                    if_id_stall;
    logic                    id_ex_stall;
    logic                    ex_mem_stall;
    logic                    id_ex_bubble;
    logic                    ex_mem_bubble;
    logic                    if_id_flush;
    logic                    id_ex_flush;
    logic                    md_start;
    logic                    md_busy;
    logic                    md_timeout_err;
    logic [CntWidth-1:0]     stall_cycles;

    // pipeline side: drives hazard sources, consumes controls
    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               ex_md_valid, ex_branch_taken, mem_req, dmem_ready, md_done,
        input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, id_ex_bubble,
               ex_mem_bubble, if_id_flush, id_ex_flush, md_start, md_busy,
               md_timeout_err, stall_cycles
    );

    // controller side
    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               ex_md_valid, ex_branch_taken, mem_req, dmem_ready, md_done,
        output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, id_ex_bubble,
               ex_mem_bubble, if_id_flush, id_ex_flush, md_start, md_busy,
               md_timeout_err, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Hold/bubble/flush sequencing for the 5-stage core: load-use, MUL/DIV wait, dmem wait, redirect.
module hazard_stall_controller #(
    parameter int unsigned RegAddrWidth = 5,
    parameter int unsigned MdTimeout    = 64,
    parameter int unsigned CntWidth     = 16
) (
    input logic                      clk,
    input logic                      rst_n,
    hazard_stall_controller_if.slave bus
);
    localparam int unsigned TmoWidth = (MdTimeout > 1) ? $clog2(MdTimeout) : 1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        MD_HOLD = 2'd2
    } state_e;

    state_e                  state;
    state_e                  state_next;
    logic [TmoWidth-1:0]     tmo_cnt;
    logic                    timeout_err;
    logic [CntWidth-1:0]     stall_cnt;

    logic                    mem_wait;
    logic                    load_use;
    logic                    rs1_hit;
    logic                    rs2_hit;
    logic                    md_timeout_hit;
    logic                    md_release;

    logic                    pc_stall;
    logic                    if_id_stall;
    logic                    id_ex_stall;
    logic                    ex_mem_stall;
    logic                    id_ex_bubble;
    logic                    ex_mem_bubble;
    logic                    if_id_flush;
    logic                    id_ex_flush;
    logic                    md_start;

    // Hazard terms; a timeout is treated exactly like a late md_done
    always_comb begin
        mem_wait       = bus.mem_req & ~bus.dmem_ready;
        rs1_hit        = bus.id_rs1_used & (bus.id_rs1 == bus.ex_rd);
        rs2_hit        = bus.id_rs2_used & (bus.id_rs2 == bus.ex_rd);
        load_use       = bus.ex_mem_read & (bus.ex_rd != RegAddrWidth'(0)) & (rs1_hit | rs2_hit);
        md_timeout_hit = (state == MD_WAIT) & ~bus.md_done &
                         (tmo_cnt == TmoWidth'(MdTimeout - 1));
        md_release     = (state == MD_WAIT) & (bus.md_done | md_timeout_hit);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (!mem_wait && bus.ex_md_valid) begin
                    state_next = MD_WAIT;
                end
            end
            MD_WAIT: begin
                if (md_release) begin
                    state_next = mem_wait ? MD_HOLD : RUN;
                end
            end
            MD_HOLD: begin
                if (!mem_wait) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Pipeline control outputs; a register is never both held and bubbled/flushed
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        ex_mem_stall  = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        md_start      = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_wait) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                end else if (bus.ex_md_valid) begin
                    md_start      = rst_n;
                    pc_stall      = 1'b1;
                    if_id_stall   = 1'b1;
                    id_ex_stall   = 1'b1;
                    ex_mem_bubble = 1'b1;
                end else if (bus.ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                end
            end
            MD_WAIT: begin
                if (!(md_release && !mem_wait)) begin
                    pc_stall      = 1'b1;
                    if_id_stall   = 1'b1;
                    id_ex_stall   = 1'b1;
                    ex_mem_stall  = mem_wait;
                    ex_mem_bubble = ~mem_wait;
                end
            end
            MD_HOLD: begin
                pc_stall     = mem_wait;
                if_id_stall  = mem_wait;
                id_ex_stall  = mem_wait;
                ex_mem_stall = mem_wait;
            end
            default: ;
        endcase
    end

    // MUL/DIV wait counter, cleared whenever not waiting
    always_ff @(posedge clk) begin
        if (!rst_n || state != MD_WAIT) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TmoWidth'(1);
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (md_timeout_hit) begin
            timeout_err <= 1'b1;
        end
    end

    // Saturating count of front-end stall cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (pc_stall && (stall_cnt != {CntWidth{1'b1}})) begin
            stall_cnt <= stall_cnt + CntWidth'(1);
        end
    end

    assign bus.pc_stall       = pc_stall;
    assign bus.if_id_stall    = if_id_stall;
    assign bus.id_ex_stall    = id_ex_stall;
    assign bus.ex_mem_stall   = ex_mem_stall;
    assign bus.id_ex_bubble   = id_ex_bubble;
    assign bus.ex_mem_bubble  = ex_mem_bubble;
    assign bus.if_id_flush    = if_id_flush;
    assign bus.id_ex_flush    = id_ex_flush;
    assign bus.md_start       = md_start;
    assign bus.md_busy        = (state != RUN);
    assign bus.md_timeout_err = timeout_err;
    assign bus.stall_cycles   = stall_cnt;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed and randomized checks of hazard_stall_controller against a behavioural model.
module tb_hazard_stall_controller;
    localparam int unsigned RW  = 5;
    localparam int unsigned TMO = 64;
    localparam int unsigned CW  = 16;
    localparam int          SAT = (1 << CW) - 1;

    typedef struct packed {
        logic pc, if_id, id_ex, ex_mem, id_ex_b, ex_mem_b, if_id_f, id_ex_f, start;
    } ctl_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_stall_controller_if #(.RegAddrWidth(RW), .CntWidth(CW)) bus ();

    hazard_stall_controller #(.RegAddrWidth(RW), .MdTimeout(TMO), .CntWidth(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int obs_pc = 0;
    int obs_start = 0;

    // behavioural model: is a MUL/DIV outstanding, has its result arrived, how long waited
    bit m_busy, m_done_seen, m_err;
    int m_waited, m_scnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ctl_t model_eval(output bit fin, output bit tmo);
        ctl_t c;
        bit mw, lu;
        c   = '0;
        fin = 1'b0;
        tmo = 1'b0;
        mw  = bus.mem_req && !bus.dmem_ready;
        lu  = bus.ex_mem_read && bus.ex_rd != 0 &&
              ((bus.id_rs1_used && bus.id_rs1 == bus.ex_rd) ||
               (bus.id_rs2_used && bus.id_rs2 == bus.ex_rd));
        if (!m_busy) begin
            if (mw)                       c = 9'b111100000;
            else if (bus.ex_md_valid)     c = {8'b11100100, rst_n};
            else if (bus.ex_branch_taken) c = 9'b000000110;
            else if (lu)                  c = 9'b110010000;
        end else if (!m_done_seen) begin
            tmo = (m_waited == TMO - 1) && !bus.md_done;
            fin = bus.md_done || tmo;
            if (!(fin && !mw)) c = mw ? 9'b111100000 : 9'b111001000;
        end else if (mw) begin
            c = 9'b111100000;
        end
        return c;
    endfunction

    task automatic model_edge();
        ctl_t e;
        bit fin, tmo, mw;
        e  = model_eval(fin, tmo);
        mw = bus.mem_req && !bus.dmem_ready;
        if (!rst_n) begin
            m_busy = 0; m_done_seen = 0; m_waited = 0; m_err = 0; m_scnt = 0;
        end else begin
            if (e.pc && m_scnt < SAT) m_scnt++;
            if (!m_busy) begin
                if (!mw && bus.ex_md_valid) begin
                    m_busy = 1; m_waited = 0; m_done_seen = 0;
                end
            end else if (!m_done_seen) begin
                if (fin) begin
                    if (tmo) m_err = 1;
                    if (mw) m_done_seen = 1;
                    else m_busy = 0;
                end else begin
                    m_waited++;
                end
            end else if (!mw) begin
                m_busy = 0; m_done_seen = 0;
            end
        end
    endtask

    function automatic ctl_t observed();
        return {bus.pc_stall, bus.if_id_stall, bus.id_ex_stall, bus.ex_mem_stall,
                bus.id_ex_bubble, bus.ex_mem_bubble, bus.if_id_flush, bus.id_ex_flush,
                bus.md_start};
    endfunction

    // one cycle: inputs already driven; check mid-cycle, then advance model at the edge
    task automatic step(input string tag);
        ctl_t e, o;
        bit fin, tmo;
        #3;
        e = model_eval(fin, tmo);
        o = observed();
        if (o.pc) obs_pc++;
        if (o.start) obs_start++;
        check({tag, ".ctl"}, 32'(o), 32'(e));
        check({tag, ".busy"}, 32'(bus.md_busy), 32'(m_busy));
        check({tag, ".err"}, 32'(bus.md_timeout_err), 32'(m_err));
        check({tag, ".scnt"}, 32'(bus.stall_cycles), 32'(m_scnt));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rs1_used = 0; bus.id_rs2_used = 0;
        bus.ex_rd = '0; bus.ex_mem_read = 0; bus.ex_md_valid = 0; bus.ex_branch_taken = 0;
        bus.mem_req = 0; bus.dmem_ready = 0; bus.md_done = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        m_busy = 0; m_done_seen = 0; m_err = 0; m_waited = 0; m_scnt = 0;
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        model_edge();
        #1;
        do_reset();
        #3;
        check("rst.scnt", 32'(bus.stall_cycles), 32'd0);
        check("rst.busy", 32'(bus.md_busy), 32'd0);
        check("rst.ctl", 32'(observed()), 32'd0);
        @(posedge clk); model_edge(); #1;

        // load-use through rs2, then the same pattern with x0
        bus.ex_mem_read = 1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_rs2_used = 1;
        #3 check("lu.ctl", 32'(observed()), 32'(9'b110010000));
        #0 step("lu");
        idle(); step("lu_after");
        check("lu.scnt", 32'(bus.stall_cycles), 32'd1);
        bus.ex_mem_read = 1; bus.ex_rd = 5'd0; bus.id_rs2 = 5'd0; bus.id_rs2_used = 1;
        #3 check("lu_x0.ctl", 32'(observed()), 32'd0);
        #0 step("lu_x0");

        // MUL/DIV with md_done 4 cycles after md_start
        do_reset();
        obs_pc = 0; obs_start = 0;
        idle(); bus.ex_md_valid = 1;
        #3 check("md.start_ctl", 32'(observed()), 32'(9'b111001001));
        #0 step("md_start");
        for (int i = 1; i <= 4; i++) begin
            bus.md_done = (i == 4);
            step("md_wait");
        end
        idle();
        check("md.pc_cycles", 32'(obs_pc), 32'd4);
        check("md.start_pulses", 32'(obs_start), 32'd1);
        check("md.scnt", 32'(bus.stall_cycles), 32'd4);
        check("md.busy_after", 32'(bus.md_busy), 32'd0);
        step("md_idle");

        // md_done during a dmem wait that lasts 3 more cycles
        bus.ex_md_valid = 1; step("hold_start");
        bus.ex_md_valid = 0;
        step("hold_wait");
        bus.md_done = 1; bus.mem_req = 1; bus.dmem_ready = 0; step("hold_done");
        bus.md_done = 0;
        for (int i = 0; i < 3; i++) begin
            #3 check("hold.ctl", 32'(observed()), 32'(9'b111100000));
            #0 step("hold");
        end
        bus.dmem_ready = 1;
        #3 check("hold.release", 32'(observed()), 32'd0);
        #0 step("hold_release");
        idle();
        check("hold.busy_after", 32'(bus.md_busy), 32'd0);

        // timeout: md_done never arrives
        do_reset();
        obs_pc = 0;
        bus.ex_md_valid = 1; step("tmo_start");
        bus.ex_md_valid = 0;
        for (int i = 0; i < TMO; i++) step("tmo_wait");
        check("tmo.pc_cycles", 32'(obs_pc), 32'(TMO));
        check("tmo.err", 32'(bus.md_timeout_err), 32'd1);
        check("tmo.busy", 32'(bus.md_busy), 32'd0);
        for (int i = 0; i < 4; i++) step("tmo_sticky");
        check("tmo.sticky", 32'(bus.md_timeout_err), 32'd1);

        // branch beats load-use; dmem wait beats branch
        bus.ex_branch_taken = 1; bus.ex_mem_read = 1; bus.ex_rd = 5'd7;
        bus.id_rs1 = 5'd7; bus.id_rs1_used = 1;
        #3 check("br_lu.ctl", 32'(observed()), 32'(9'b000000110));
        #0 step("br_lu");
        bus.mem_req = 1; bus.dmem_ready = 0;
        #3 check("br_mw.ctl", 32'(observed()), 32'(9'b111100000));
        #0 step("br_mw");
        idle();

        // reset in the middle of MD_WAIT
        bus.ex_md_valid = 1; step("rmw_start");
        bus.ex_md_valid = 0;
        for (int i = 0; i < 3; i++) step("rmw_wait");
        rst_n = 0; step("rmw_reset");
        rst_n = 1;
        check("rmw.busy", 32'(bus.md_busy), 32'd0);
        check("rmw.err", 32'(bus.md_timeout_err), 32'd0);
        check("rmw.scnt", 32'(bus.stall_cycles), 32'd0);
        step("rmw_after");

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            bus.id_rs1 = RW'($urandom_range(0, 3));
            bus.id_rs2 = RW'($urandom_range(0, 3));
            bus.id_rs1_used = 1'($urandom);
            bus.id_rs2_used = 1'($urandom);
            bus.ex_rd = RW'($urandom_range(0, 3));
            bus.ex_mem_read = 1'($urandom);
            bus.ex_md_valid = ($urandom_range(0, 5) == 0);
            bus.ex_branch_taken = ($urandom_range(0, 3) == 0);
            bus.mem_req = 1'($urandom);
            bus.dmem_ready = ($urandom_range(0, 2) != 0);
            bus.md_done = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        // continuous stall to saturate the counter
        do_reset();
        bus.mem_req = 1; bus.dmem_ready = 0;
        for (int i = 0; i < SAT + 4; i++) begin
            @(posedge clk);
            model_edge();
        end
        #1;
        step("sat");
        check("sat.scnt", 32'(bus.stall_cycles), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
